// File: rtl/mul_issuer_pkg.sv
// rtl/mul_issuer_pkg.sv - shared states and constants for the shift-add multiplier issuer
package mul_issuer_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_RUN  = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Default shift-add iteration count (one per multiplier bit)
    localparam int MUL_ITER    = 32;
    // Maximum RUN+WAIT cycles before the control-unit handshake is declared failed
    localparam int MUL_TIMEOUT = 63;
    // Cycles ctrl_rst is held so the control unit's negedge logic sees its reset
    localparam int CLR_LEN     = 2;

    localparam int STEP_W = 6;
    localparam int CYC_W  = 7;

endpackage

// File: rtl/mul_shift_add.sv
// rtl/mul_shift_add.sv - 65-bit shift-add accumulator producing an unsigned 32x32 product
module mul_shift_add (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [64:0] acc
);

    logic [64:0] r_acc;
    logic [32:0] w_sum;
    logic [64:0] w_acc_next;

    // One step: conditionally add A into the upper half, then shift right keeping the carry bit
    always_comb begin
        w_sum      = {1'b0, r_acc[63:32]} + {1'b0, A};
        w_acc_next = r_acc;
        if (load) begin
            w_acc_next = {33'b0, B};
        end else if (step) begin
            if (r_acc[0]) begin
                w_acc_next = {1'b0, w_sum, r_acc[31:1]};
            end else begin
                w_acc_next = {1'b0, r_acc[64:1]};
            end
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_next;
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/mul_issuer.sv
// rtl/mul_issuer.sv - multiplier issuer FSM with external iteration-count control handshake
module mul_issuer
    import mul_issuer_pkg::*;
#(
    parameter int ITER    = MUL_ITER,
    parameter int TIMEOUT = MUL_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        ctrl_rst,
    output logic        counting,
    input  logic        ctrl_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        err
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ITER - 1);
    localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(TIMEOUT - 1);
    localparam logic [1:0]        LAST_CLR  = 2'(CLR_LEN - 1);

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_a;
    logic [STEP_W-1:0]   r_step;
    logic [CYC_W-1:0]    r_cyc;
    logic [1:0]          r_clr;
    logic                r_err;
    logic                r_ctrl_rst;
    logic                w_accept;
    logic                w_timeout;
    logic [64:0]         w_acc;
    logic                w_unused_msb;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_timeout = (r_cyc >= LAST_CYC);

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)            w_next = S_CLR;
            S_CLR:  if (r_clr == LAST_CLR)   w_next = S_RUN;
            S_RUN:  if (r_step == LAST_STEP) w_next = S_WAIT;
            S_WAIT: if (ctrl_ready || w_timeout) w_next = S_DONE;
            S_DONE: if (out_ready)           w_next = S_IDLE;
            default:                         w_next = S_IDLE;
        endcase
    end

    // State register; ctrl_rst is registered so it is high out of reset and exactly during CLR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ctrl_rst <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_ctrl_rst <= (w_next == S_CLR);
        end
    end

    // Operand latch, counters and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_step <= '0;
            r_cyc  <= '0;
            r_clr  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a    <= multiplicand;
                        r_step <= '0;
                        r_cyc  <= '0;
                        r_clr  <= '0;
                        r_err  <= 1'b0;
                    end
                end
                S_CLR: r_clr <= r_clr + 2'd1;
                S_RUN: begin
                    r_step <= r_step + 1'b1;
                    r_cyc  <= r_cyc + 1'b1;
                    // Ready before all steps are done means the control unit miscounted
                    if (ctrl_ready) begin
                        r_err <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_cyc <= r_cyc + 1'b1;
                    if (!ctrl_ready && w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mul_shift_add u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept),
        .step  (r_state == S_RUN),
        .A     (r_a),
        .B     (multiplier),
        .acc   (w_acc)
    );

    assign w_unused_msb = w_acc[64];
    assign in_ready     = (r_state == S_IDLE);
    assign counting     = (r_state == S_RUN) || (r_state == S_WAIT);
    assign out_valid    = (r_state == S_DONE);
    assign ctrl_rst     = r_ctrl_rst;
    assign product      = w_acc[63:0];
    assign err          = r_err;

endmodule

// File: tb/tb_mul_issuer.sv
// tb/tb_mul_issuer.sv - self-checking bench for mul_issuer
module tb_mul_issuer;
    import mul_issuer_pkg::*;

    localparam int LAT_MODEL   = 2 + MUL_ITER + 1 + 1;
    localparam int LAT_TIMEOUT = 2 + MUL_ITER + (MUL_TIMEOUT - MUL_ITER) + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        in_ready, ctrl_rst, counting, ctrl_ready, out_valid, err;
    logic [63:0] product;

    int mode = 0;
    int cu_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          mode;
        logic [63:0] p;
        logic        e;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    mul_issuer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (a_in),
        .multiplier   (b_in),
        .ctrl_rst     (ctrl_rst),
        .counting     (counting),
        .ctrl_ready   (ctrl_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .err          (err)
    );

    always #5 clk = ~clk;

    // External control unit: counts while counting, ready once the count reaches ITER
    always @(posedge clk) begin
        if (ctrl_rst) cu_cnt <= 0;
        else if (counting) cu_cnt <= cu_cnt + 1;
    end

    assign ctrl_ready = (mode == 1) ? 1'b0 :
                        ((cu_cnt >= MUL_ITER) || (mode == 2 && counting && cu_cnt == 10));

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_accept(input logic [31:0] a, input logic [31:0] b);
        int k;
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check64("accept_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int clr_n, output int cnt_n);
        lat = 1;
        clr_n = 0;
        cnt_n = 0;
        while (!out_valid && lat < 200) begin
            clr_n += int'(ctrl_rst);
            cnt_n += int'(counting);
            @(posedge clk); #1;
            lat++;
        end
        check64("out_valid_seen", 64'(out_valid), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat, clr_n, cnt_n;
        mode = v.mode;
        out_ready = 1'b1;
        do_accept(v.a, v.b);
        wait_result(lat, clr_n, cnt_n);
        check64({name, "_product"}, product, v.p);
        check64({name, "_err"}, 64'(err), 64'(v.e));
        check64({name, "_latency"}, 64'(lat), 64'(v.lat));
        check64({name, "_clr_cycles"}, 64'(clr_n), 64'(CLR_LEN));
        check64({name, "_count_cycles"}, 64'(cnt_n), 64'(v.lat - 1 - CLR_LEN));
        @(posedge clk); #1;
        check64({name, "_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int   lat, clr_n, cnt_n, k, seen;
        vec_t v;

        vecs[0] = '{32'd3, 32'd5, 0, 64'd15, 1'b0, LAT_MODEL};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001, 1'b0, LAT_MODEL};
        vecs[2] = '{32'd1000, 32'd1000, 1, 64'd1000000, 1'b1, LAT_TIMEOUT};
        vecs[3] = '{32'hDEAD_BEEF, 32'd2, 2, 64'h1_BD5B_7DDE, 1'b1, LAT_MODEL};
        vecs[4] = '{32'd100, 32'd200, 0, 64'd20000, 1'b0, LAT_MODEL};
        vecs[5] = '{32'd0, 32'hFFFF_FFFF, 0, 64'd0, 1'b0, LAT_MODEL};
        vecs[6] = '{32'hFFFF_FFFF, 32'd1, 0, 64'h0000_0000_FFFF_FFFF, 1'b0, LAT_MODEL};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 0, 64'h4000_0000_0000_0000, 1'b0, LAT_MODEL};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check64("rst_in_ready", 64'(in_ready), 64'd1);
        check64("rst_out_valid", 64'(out_valid), 64'd0);
        check64("rst_counting", 64'(counting), 64'd0);
        check64("rst_ctrl_rst", 64'(ctrl_rst), 64'd1);
        check64("rst_err", 64'(err), 64'd0);
        check64("rst_product", product, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check64("rst_release_ctrl_rst", 64'(ctrl_rst), 64'd0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Randomized operations against the arithmetic reference
        for (int i = 0; i < 20; i++) begin
            v.a = $urandom;
            v.b = $urandom;
            if ($urandom_range(0, 3) == 0) v.a = 32'hFFFF_FFFF;
            v.mode = int'($urandom_range(0, 2));
            v.p = {32'b0, v.a} * {32'b0, v.b};
            v.e = (v.mode != 0);
            v.lat = (v.mode == 1) ? LAT_TIMEOUT : LAT_MODEL;
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Output back-pressure with a new pair waiting
        mode = 0;
        out_ready = 1'b0;
        do_accept(32'd9, 32'd11);
        wait_result(lat, clr_n, cnt_n);
        check64("bp_first_product", product, 64'd99);
        a_in = 32'd4;
        b_in = 32'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check64("bp_hold_valid", 64'(out_valid), 64'd1);
            check64("bp_hold_product", product, 64'd99);
            check64("bp_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check64("bp_release_valid", 64'(out_valid), 64'd0);
        check64("bp_release_in_ready", 64'(in_ready), 64'd1);
        do_accept(32'd4, 32'd5);
        wait_result(lat, clr_n, cnt_n);
        check64("bp_second_product", product, 64'd20);
        check64("bp_second_latency", 64'(lat), 64'(LAT_MODEL));
        @(posedge clk); #1;
        check64("bp_second_drop", 64'(out_valid), 64'd0);

        // Reset in the middle of RUN
        mode = 0;
        do_accept(32'hAAAA_5555, 32'h1234_5678);
        k = 0;
        while (cu_cnt != 16 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check64("mid_reached_step16", 64'(cu_cnt), 64'd16);
        rst_n = 1'b0;
        #1;
        check64("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check64("mid_rst_counting", 64'(counting), 64'd0);
        check64("mid_rst_ctrl_rst", 64'(ctrl_rst), 64'd1);
        check64("mid_rst_product", product, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check64("mid_release_ctrl_rst", 64'(ctrl_rst), 64'd0);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        check64("mid_no_result", 64'(seen), 64'd0);
        v = '{32'd7, 32'd6, 0, 64'd42, 1'b0, LAT_MODEL};
        run_vec(v, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_issuer.md
MUL_ISSUER -- requirements
Module: mul_issuer

Interface
REQ-001 The block SHALL have parameter ITER, default 32, giving the number of shift-add iterations per operation.
REQ-002 The block SHALL have parameter TIMEOUT, default 63, giving the maximum number of RUN+WAIT cycles before an error is declared.
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  an operand pair is offered.
- in_ready  out  1  the block accepts the pair this cycle.
- multiplicand  in  32  unsigned operand A.
- multiplier  in  32  unsigned operand B.
- ctrl_rst  out  1  drives rst of the external iteration-count control unit.
- counting  out  1  drives counting of that control unit.
- ctrl_ready  in  1  ready from that control unit.
- out_valid  out  1  product/err valid.
- out_ready  in  1  downstream accepts the result.
- product  out  64  unsigned A*B.
- err  out  1  the control unit handshake failed for this result.

Function
REQ-004 The state machine SHALL have states IDLE, CLR, RUN, WAIT, DONE.
REQ-005 in_ready SHALL be 1 only in IDLE; an in_valid&in_ready cycle SHALL latch A and B, load the accumulator with {33'b0, B}, clear the step and cycle counters and err, and move to CLR.
REQ-006 CLR SHALL assert ctrl_rst=1 and counting=0 for exactly 2 cycles, so that the control unit's posedge-registered reset is seen by its negedge logic, then move to RUN.
REQ-007 In RUN and WAIT, counting SHALL be 1; in every other state it SHALL be 0.
REQ-008 Each RUN cycle SHALL perform one shift-add step and increment the 6-bit step counter; when it reaches ITER, the block SHALL move to WAIT.
- Shift-add step: if acc[0], acc[64:32] = acc[63:32] + A as a 33-bit sum; then acc is shifted right by 1.
REQ-009 In WAIT, ctrl_ready=1 SHALL move the block to DONE with err unchanged.
REQ-010 ctrl_ready=1 sampled in RUN (an early ready) SHALL set err=1; RUN SHALL still complete all ITER steps.
REQ-011 The cycle counter SHALL count RUN+WAIT cycles; on reaching TIMEOUT while in WAIT, the block SHALL set err=1 and move to DONE.
REQ-012 In DONE, out_valid SHALL be 1 and product SHALL equal acc[63:0].
- product and err SHALL be held stable until out_ready=1.
- out_valid&out_ready SHALL return the block to IDLE in the same cycle, with out_valid=0 on the next cycle.
REQ-013 in_valid SHALL be ignored outside IDLE; no operand SHALL be lost or double-accepted.
REQ-014 Latency from accept to out_valid SHALL be 2+ITER+W+1 cycles, where W is the number of cycles spent in WAIT (W≥1).
REQ-015 Arithmetic SHALL be unsigned modulo nothing: the full 64-bit product SHALL be exact, and the 33rd sum bit SHALL be preserved by the shift.

Reset
REQ-016 rst_n=0 SHALL asynchronously force IDLE with these values: in_ready=1, out_valid=0, counting=0, ctrl_rst=1, err=0, product=0, and all counters 0.
REQ-017 Reset asserted mid-operation SHALL discard the operation without emitting a result.
REQ-018 ctrl_rst SHALL return to 0 on the first clk edge after rst_n deasserts.

Structure
REQ-019 The state enum, ITER, TIMEOUT, and the CLR length (2) SHALL reside in the shared package mul_issuer_pkg.
REQ-020 The shift-add accumulator SHALL be a sub-module mul_shift_add, with inputs clk, rst_n, load, step, A, B and output acc[64:0].
- The FSM, counters and handshakes SHALL stay in mul_issuer.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- A=3, B=5, with a model of the control unit asserting ready after its count reaches 32 -> product=15, err=0, out_valid at the computed latency.
- A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001, err=0.
- ctrl_ready tied 0 -> err=1 with out_valid after exactly TIMEOUT RUN+WAIT cycles; product still correct.
- ctrl_ready pulsed at RUN step 10 -> err=1, product correct; a following clean operation reports err=0.
- out_ready held 0 for 5 cycles in DONE, with in_valid=1 and new operands -> product stable, in_ready=0, second pair accepted only after the output handshake.
- rst_n pulsed low at RUN step 16 -> IDLE, no out_valid; the next operation A=7, B=6 -> product=42.
